// File: rtl/stripe_pattern_detector.sv
// Alternating white-run / black-run stripe recogniser fed by per-pixel colour
// strobes; raises a sticky building flag once NUM_STRIPES pairs are seen.
module stripe_pattern_detector #(
  parameter int CNT_W       = 8,
  parameter int WHITE_MIN   = 5,
  parameter int BLACK_MIN   = 5,
  parameter int NUM_STRIPES = 1,
  parameter int TIMEOUT     = 1024,
  parameter int TMR_W       = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             sof,
  input  logic             clear,
  input  logic             white_detect,
  input  logic             black_detect,
  output logic             building_found,
  output logic             found_pulse,
  output logic [CNT_W-1:0] white_count,
  output logic [CNT_W-1:0] black_count,
  output logic [3:0]       stripe_count,
  output logic [1:0]       state
);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_WHITE = 2'd1, S_BLACK = 2'd2, S_FOUND = 2'd3} state_t;

  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [CNT_W-1:0] WMIN     = CNT_W'(WHITE_MIN);
  localparam logic [CNT_W-1:0] BMIN     = CNT_W'(BLACK_MIN);
  localparam logic [CNT_W-1:0] BMIN_M1  = CNT_W'(BLACK_MIN - 1);
  localparam logic [3:0]       NSTR     = 4'(NUM_STRIPES);
  localparam logic [TMR_W-1:0] TO_LAST  = TMR_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

  state_t             r_state;
  logic [CNT_W-1:0]   r_white, r_black;
  logic [3:0]         r_stripe;
  logic [TMR_W-1:0]   r_timer;
  logic               r_found, r_pulse;

  logic               w_white, w_black;
  logic [CNT_W-1:0]   w_white_inc, w_black_inc;
  logic [3:0]         w_stripe_inc;

  // A strobe only counts when exactly one colour is asserted.
  assign w_white      = white_detect & ~black_detect;
  assign w_black      = black_detect & ~white_detect;
  assign w_white_inc  = (r_white == CNT_MAX) ? r_white : r_white + 1'b1;
  assign w_black_inc  = (r_black == CNT_MAX) ? r_black : r_black + 1'b1;
  assign w_stripe_inc = r_stripe + 4'd1;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state  <= S_IDLE;
      r_white  <= '0;
      r_black  <= '0;
      r_stripe <= '0;
      r_timer  <= '0;
      r_found  <= 1'b0;
      r_pulse  <= 1'b0;
    end else begin
      r_pulse <= 1'b0;
      if (sof | clear) begin
        r_state  <= S_IDLE;
        r_white  <= '0;
        r_black  <= '0;
        r_stripe <= '0;
        r_timer  <= '0;
        r_found  <= 1'b0;
      end else begin
        case (r_state)
          S_IDLE: begin
            r_timer <= '0;
            if (w_white) begin
              r_state <= S_WHITE;
              r_white <= CNT_W'(1);
              r_black <= '0;
            end
          end

          S_WHITE: begin
            if (w_white) begin
              r_white <= w_white_inc;
              r_timer <= '0;
            end else if (w_black) begin
              r_timer <= '0;
              if (r_white >= WMIN) begin
                r_state <= S_BLACK;
                r_black <= CNT_W'(1);
                // With a one-strobe black run the entering strobe closes the pair.
                if (BLACK_MIN == 1) begin
                  r_stripe <= w_stripe_inc;
                  if (w_stripe_inc == NSTR) begin
                    r_state <= S_FOUND;
                    r_found <= 1'b1;
                    r_pulse <= 1'b1;
                  end
                end
              end else begin
                r_state  <= S_IDLE;
                r_white  <= '0;
                r_black  <= '0;
                r_stripe <= '0;
              end
            end else if (TIMEOUT != 0) begin
              if (r_timer == TO_LAST) begin
                r_state  <= S_IDLE;
                r_white  <= '0;
                r_black  <= '0;
                r_stripe <= '0;
                r_timer  <= '0;
              end else begin
                r_timer <= r_timer + 1'b1;
              end
            end
          end

          S_BLACK: begin
            if (w_black) begin
              r_black <= w_black_inc;
              r_timer <= '0;
              if (r_black == BMIN_M1) begin
                r_stripe <= w_stripe_inc;
                if (w_stripe_inc == NSTR) begin
                  r_state <= S_FOUND;
                  r_found <= 1'b1;
                  r_pulse <= 1'b1;
                end
              end
            end else if (w_white) begin
              r_state <= S_WHITE;
              r_white <= CNT_W'(1);
              r_black <= '0;
              r_timer <= '0;
              // A short black run breaks the pattern; this white run starts afresh.
              if (r_black < BMIN) r_stripe <= '0;
            end else if (TIMEOUT != 0) begin
              if (r_timer == TO_LAST) begin
                r_state  <= S_IDLE;
                r_white  <= '0;
                r_black  <= '0;
                r_stripe <= '0;
                r_timer  <= '0;
              end else begin
                r_timer <= r_timer + 1'b1;
              end
            end
          end

          default: r_timer <= '0;
        endcase
      end
    end
  end

  assign building_found = r_found;
  assign found_pulse    = r_pulse;
  assign white_count    = r_white;
  assign black_count    = r_black;
  assign stripe_count   = r_stripe;
  assign state          = r_state;

endmodule

// File: tb/tb_stripe_pattern_detector.sv
// Bench for stripe_pattern_detector: DUT A uses defaults, DUT B uses two
// stripes and an 8-cycle timeout; both share one stimulus stream.
module tb_stripe_pattern_detector;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       sof = 1'b0, clear = 1'b0, wd = 1'b0, bd = 1'b0;

  logic       a_bf, a_fp, b_bf, b_fp;
  logic [7:0] a_wc, a_bc, b_wc, b_bc;
  logic [3:0] a_sc, b_sc;
  logic [1:0] a_st, b_st;

  always #5 clk = ~clk;

  stripe_pattern_detector u_a (
    .clk(clk), .reset_n(reset_n), .sof(sof), .clear(clear),
    .white_detect(wd), .black_detect(bd),
    .building_found(a_bf), .found_pulse(a_fp), .white_count(a_wc),
    .black_count(a_bc), .stripe_count(a_sc), .state(a_st));

  stripe_pattern_detector #(.NUM_STRIPES(2), .TIMEOUT(8)) u_b (
    .clk(clk), .reset_n(reset_n), .sof(sof), .clear(clear),
    .white_detect(wd), .black_detect(bd),
    .building_found(b_bf), .found_pulse(b_fp), .white_count(b_wc),
    .black_count(b_bc), .stripe_count(b_sc), .state(b_st));

  typedef struct {
    logic       sof, clr, w, b;
    logic       sel;
    logic [1:0] st;
    logic [7:0] wc, bc;
    logic [3:0] sc;
    logic       bf, fp;
    string      nm;
  } vec_t;

  vec_t vecs[$];
  vec_t exp_q[$];
  int   n_chk = 0;
  int   n_err = 0;

  function automatic vec_t mk(logic s, logic c, logic w, logic b, logic sel,
                              logic [1:0] st, logic [7:0] wc, logic [7:0] bc,
                              logic [3:0] sc, logic bf, logic fp, string nm);
    vec_t v;
    v.sof = s; v.clr = c; v.w = w; v.b = b; v.sel = sel;
    v.st = st; v.wc = wc; v.bc = bc; v.sc = sc; v.bf = bf; v.fp = fp; v.nm = nm;
    return v;
  endfunction

  function automatic void add(logic s, logic c, logic w, logic b, logic sel,
                              logic [1:0] st, logic [7:0] wc, logic [7:0] bc,
                              logic [3:0] sc, logic bf, logic fp, string nm);
    vecs.push_back(mk(s, c, w, b, sel, st, wc, bc, sc, bf, fp, nm));
  endfunction

  function automatic void cmp(vec_t e);
    logic [23:0] act, exp;
    exp = {e.st, e.wc, e.bc, e.sc, e.bf, e.fp};
    act = e.sel ? {b_st, b_wc, b_bc, b_sc, b_bf, b_fp}
                : {a_st, a_wc, a_bc, a_sc, a_bf, a_fp};
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s dut%s: got st=%0d wc=%0d bc=%0d sc=%0d bf=%0b fp=%0b, want st=%0d wc=%0d bc=%0d sc=%0d bf=%0b fp=%0b",
               e.nm, e.sel ? "B" : "A", act[23:22], act[21:14], act[13:6], act[5:2], act[1], act[0],
               e.st, e.wc, e.bc, e.sc, e.bf, e.fp);
    end
  endfunction

  task automatic drive(vec_t v);
    @(negedge clk);
    sof = v.sof; clear = v.clr; wd = v.w; bd = v.b;
    exp_q.push_back(v);
  endtask

  task automatic drive_nc(logic w, logic b);
    @(negedge clk);
    sof = 1'b0; clear = 1'b0; wd = w; bd = b;
  endtask

  // Scoreboard: expectations queued at drive time, checked just after the edge.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) cmp(exp_q.pop_front());
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // ---- DUT A, defaults: one stripe pair ----
    add(0,1,0,0, 0, 0,0,0,0,0,0, "clrA");
    for (int i = 1; i <= 5; i++) add(0,0,1,0, 0, 1,8'(i),0,0,0,0, "w5");
    for (int i = 1; i <= 4; i++) add(0,0,0,1, 0, 2,5,8'(i),0,0,0, "b4");
    add(0,0,0,1, 0, 3,5,5,1,1,1, "found");
    add(0,0,0,0, 0, 3,5,5,1,1,0, "pulse_drop");
    add(0,0,1,0, 0, 3,5,5,1,1,0, "found_ign_w");
    add(0,0,0,1, 0, 3,5,5,1,1,0, "found_ign_b");
    add(1,0,1,0, 0, 0,0,0,0,0,0, "sof_w_in_found");
    for (int i = 1; i <= 4; i++) add(0,0,1,0, 0, 1,8'(i),0,0,0,0, "w4");
    add(0,0,0,1, 0, 0,0,0,0,0,0, "short_white_abort");
    add(0,0,0,1, 0, 0,0,0,0,0,0, "idle_ign_b");
    add(0,0,1,0, 0, 1,1,0,0,0,0, "w1");
    add(0,0,1,0, 0, 1,2,0,0,0,0, "w2");
    for (int i = 0; i < 3; i++) add(0,0,1,1, 0, 1,2,0,0,0,0, "both_hold");

    // ---- DUT B, two stripes: W5 B5 W6 B5 ----
    add(0,1,0,0, 1, 0,0,0,0,0,0, "clrB");
    for (int i = 1; i <= 5; i++) add(0,0,1,0, 1, 1,8'(i),0,0,0,0, "B_w5");
    for (int i = 1; i <= 4; i++) add(0,0,0,1, 1, 2,5,8'(i),0,0,0, "B_b4");
    add(0,0,0,1, 1, 2,5,5,1,0,0, "B_pair1");
    for (int i = 1; i <= 6; i++) add(0,0,1,0, 1, 1,8'(i),0,1,0,0, "B_w6");
    for (int i = 1; i <= 4; i++) add(0,0,0,1, 1, 2,6,8'(i),1,0,0, "B_b4b");
    add(0,0,0,1, 1, 3,6,5,2,1,1, "B_found");
    add(0,0,0,0, 1, 3,6,5,2,1,0, "B_pulse_drop");
    add(0,1,0,0, 1, 0,0,0,0,0,0, "B_clear_found");
    // W5 B5 W5 B3 W1: short black run restarts the stripe count
    for (int i = 1; i <= 5; i++) add(0,0,1,0, 1, 1,8'(i),0,0,0,0, "R_w5");
    for (int i = 1; i <= 5; i++) add(0,0,0,1, 1, 2,5,8'(i),(i == 5) ? 4'd1 : 4'd0,0,0, "R_b5");
    for (int i = 1; i <= 5; i++) add(0,0,1,0, 1, 1,8'(i),0,1,0,0, "R_w5b");
    for (int i = 1; i <= 3; i++) add(0,0,0,1, 1, 2,5,8'(i),1,0,0, "R_b3");
    add(0,0,1,0, 1, 1,1,0,0,0,0, "R_restart");

    // ---- DUT B, timeout 8 ----
    add(0,1,0,0, 1, 0,0,0,0,0,0, "T_clr");
    for (int i = 1; i <= 3; i++) add(0,0,1,0, 1, 1,8'(i),0,0,0,0, "T_w3");
    for (int i = 1; i <= 7; i++) add(0,0,0,0, 1, 1,3,0,0,0,0, "T_idle7");
    add(0,0,0,0, 1, 0,0,0,0,0,0, "T_timeout");
    for (int i = 1; i <= 3; i++) add(0,0,1,0, 1, 1,8'(i),0,0,0,0, "T_w3b");
    for (int i = 1; i <= 7; i++) add(0,0,0,0, 1, 1,3,0,0,0,0, "T_idle7b");
    add(0,0,1,0, 1, 1,4,0,0,0,0, "T_rearm");
    for (int i = 1; i <= 7; i++) add(0,0,1,1, 1, 1,4,0,0,0,0, "T_both_idle");
    add(0,0,0,0, 1, 0,0,0,0,0,0, "T_timeout2");

    // ---- reset state ----
    #3;
    cmp(mk(0,0,0,0, 0, 0,0,0,0,0,0, "reset_A"));
    cmp(mk(0,0,0,0, 1, 0,0,0,0,0,0, "reset_B"));
    @(negedge clk);
    reset_n = 1'b1;

    foreach (vecs[i]) drive(vecs[i]);

    // ---- saturation on DUT A ----
    drive(mk(0,1,0,0, 0, 0,0,0,0,0,0, "S_clr"));
    for (int i = 0; i < 299; i++) drive_nc(1, 0);
    drive(mk(0,0,1,0, 0, 1,255,0,0,0,0, "S_w300"));
    drive(mk(0,0,0,1, 0, 2,255,1,0,0,0, "S_black_after_sat"));

    // ---- async reset mid-BLACK on DUT A ----
    drive(mk(0,1,0,0, 0, 0,0,0,0,0,0, "AR_clr"));
    for (int i = 1; i <= 5; i++) drive(mk(0,0,1,0, 0, 1,8'(i),0,0,0,0, "AR_w5"));
    drive(mk(0,0,0,1, 0, 2,5,1,0,0,0, "AR_b1"));
    drive(mk(0,0,0,1, 0, 2,5,2,0,0,0, "AR_b2"));
    @(negedge clk);
    wd = 1'b0; bd = 1'b0;
    #2 reset_n = 1'b0;
    #1 cmp(mk(0,0,0,0, 0, 0,0,0,0,0,0, "async_reset"));
    @(negedge clk);
    reset_n = 1'b1;
    for (int i = 1; i <= 5; i++) drive(mk(0,0,1,0, 0, 1,8'(i),0,0,0,0, "PR_w5"));
    for (int i = 1; i <= 4; i++) drive(mk(0,0,0,1, 0, 2,5,8'(i),0,0,0, "PR_b4"));
    drive(mk(0,0,0,1, 0, 3,5,5,1,1,1, "PR_found"));

    @(negedge clk);
    wd = 1'b0; bd = 1'b0;
    @(posedge clk);
    #3;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
